adc_stream_ctrl: RTL and testbench
==================================

ADC_STREAM_CTRL -- requirements
Module: adc_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_BIT, default 6, ADC sample width, legal 1..16.
REQ-002 SHALL have parameter NUM_CH, default 4, multiplexed ADC channel count, legal 1..16.
REQ-003 SHALL have parameter NUM_SAMPLED, default 125000, samples per capture run, legal 1..2^24-1.
REQ-004 SHALL have parameter NUM_CALIB, default 1000, clock cycles adc_calib_ena is held.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, sample buffer depth, power of two, legal 2..256.
REQ-006 clk  in  1  system clock; all logic rising-edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cmd_data  in  8  command byte from UART receiver; cmd_vld  in  1  one-cycle strobe qualifying it.
REQ-009 adc_ack  in  1  one-cycle strobe, adc_dout valid; adc_dout  in  NUM_BIT  conversion result.
REQ-010 adc_ena  out  1  conversion enable; adc_calib_ena  out  1  calibration enable; adc_ch_sel  out  max(1,clog2(NUM_CH))  channel select.
REQ-011 tx_wdata  out  8  byte to UART transmitter; tx_wreq  out  1  write request; tx_rdy  in  1  transmitter ready.
REQ-012 state  out  3  FSM state code; sample_cnt  out  24  samples accepted this run; overflow  out  1  sticky FIFO overflow flag.

Function
REQ-013 States/codes: IDLE=0, CALIB=1, CAPTURE=2, DRAIN=3, DONE=4; state output SHALL equal current code.
REQ-014 IDLE, cmd_vld with 0x53 ('S') -> CAPTURE; clears sample_cnt, overflow, adc_ch_sel, FIFO.
REQ-015 IDLE, cmd_vld with 0x43 ('C') -> CALIB; adc_calib_ena=1 for exactly NUM_CALIB cycles, then IDLE; no bytes transmitted.
REQ-016 cmd_vld with 0x52 ('R') in any state SHALL act as rst on the next edge; all other command bytes SHALL be ignored, including 'S'/'C' outside IDLE.
REQ-017 CAPTURE: adc_ena=1; each adc_ack SHALL write {channel, adc_dout} to FIFO, increment sample_cnt, advance adc_ch_sel modulo NUM_CH (wrap NUM_CH-1 -> 0).
REQ-018 adc_ack while FIFO full SHALL drop the sample, set overflow, still increment sample_cnt and advance adc_ch_sel.
REQ-019 When sample_cnt reaches NUM_SAMPLED: adc_ena deasserts next cycle, state -> DRAIN; later adc_ack ignored.
REQ-020 DRAIN -> DONE when FIFO empty and serializer idle; DONE -> IDLE after one cycle.
REQ-021 Serializer SHALL run in CAPTURE and DRAIN, popping one FIFO entry when idle and FIFO non-empty.
REQ-022 Byte format per sample: byte0 = {channel[3:0], 3'b000, overflow}; then sample zero-extended to 16 bits, MSB byte first if NUM_BIT>8, else single low byte.
REQ-023 Handshake: tx_wdata stable while tx_wreq=1; a byte is consumed on a cycle with tx_wreq=1 and tx_rdy=1; tx_wreq SHALL drop or present the next byte the following cycle.
REQ-024 Simultaneous FIFO write and pop when full SHALL succeed (pop frees the slot), no overflow.
REQ-025 Latency: adc_ack into empty FIFO with idle serializer and tx_rdy=1 -> tx_wreq high within 2 cycles.

Reset
REQ-026 On rst (or 'R'): state=IDLE, adc_ena=0, adc_calib_ena=0, adc_ch_sel=0, tx_wreq=0, tx_wdata=0, sample_cnt=0, overflow=0, FIFO empty, serializer idle; in-flight byte abandoned.

Verification
REQ-027 rst, cmd 0x43 -> adc_calib_ena high exactly NUM_CALIB cycles, state 1->0, tx_wreq never high.
REQ-028 NUM_CH=4, NUM_SAMPLED=6, cmd 0x53, six acks with dout 1..6, tx_rdy=1 -> adc_ch_sel 0,1,2,3,0,1; 12 bytes, byte pairs {0x00,0x01},{0x10,0x02}..{0x10,0x06}; state ends 0.
REQ-029 tx_rdy=0, FIFO_DEPTH=4, five acks -> overflow=1, sample_cnt=5; after tx_rdy=1 four samples sent, overflow bit set in their byte0.
REQ-030 'R' mid-CAPTURE while tx_wreq=1 -> next cycle all outputs at reset values.
REQ-031 NUM_BIT=12, dout 0xABC on channel 2 -> bytes 0x20, 0x0A, 0xBC; tx_wdata held while tx_rdy=0.
REQ-032 Garbage command 0x00 and 'C' during CAPTURE -> no state change.

Source files
------------

// File: rtl/adc_stream_ctrl.sv
// ADC capture controller: UART command decode, channel-multiplexed sample capture
// into a small FIFO, and byte serialization of buffered samples to a UART transmitter.
module adc_stream_ctrl #(
   parameter int NUM_BIT     = 6,
   parameter int NUM_CH      = 4,
   parameter int NUM_SAMPLED = 125000,
   parameter int NUM_CALIB   = 1000,
   parameter int FIFO_DEPTH  = 16,
   localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         cmd_data,
   input  logic               cmd_vld,
   input  logic               adc_ack,
   input  logic [NUM_BIT-1:0] adc_dout,
   output logic               adc_ena,
   output logic               adc_calib_ena,
   output logic [CHW-1:0]     adc_ch_sel,
   output logic [7:0]         tx_wdata,
   output logic               tx_wreq,
   input  logic               tx_rdy,
   output logic [2:0]         state,
   output logic [23:0]        sample_cnt,
   output logic               overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = CHW + NUM_BIT;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CALIB   = 3'd1,
      S_CAPTURE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_adc_ena;
   logic            r_calib_ena;
   logic [CHW-1:0]  r_ch_sel;
   logic [23:0]     r_sample_cnt;
   logic            r_overflow;
   logic [31:0]     r_calib_cnt;

   logic [EW-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;

   logic            r_tx_wreq;
   logic [7:0]      r_tx_wdata;
   logic [7:0]      r_b1;
   logic [7:0]      r_b2;
   logic [1:0]      r_left;

   logic            w_rst;
   logic            w_cmd_s;
   logic            w_cmd_c;
   logic            w_start;
   logic            w_ack_cap;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic            w_last;
   logic [EW-1:0]   w_rd_ent;
   logic [3:0]      w_rd_ch4;
   logic [15:0]     w_rd_s16;

   // An 'R' command byte behaves exactly like the external reset.
   assign w_rst     = rst | (cmd_vld & (cmd_data == 8'h52));
   assign w_cmd_s   = cmd_vld & (cmd_data == 8'h53);
   assign w_cmd_c   = cmd_vld & (cmd_data == 8'h43);
   assign w_start   = (r_state == S_IDLE) & w_cmd_s;
   assign w_ack_cap = adc_ack & (r_state == S_CAPTURE);
   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_last    = (r_sample_cnt == 24'(NUM_SAMPLED - 1));

   // Pops wait for tx_rdy so that a stalled transmitter leaves every sample in the
   // FIFO, where it picks up the overflow flag as it stands when finally sent.
   assign w_pop  = ((r_state == S_CAPTURE) | (r_state == S_DRAIN)) & ~r_tx_wreq & ~w_empty & tx_rdy;
   assign w_push = w_ack_cap & (~w_full | w_pop);
   assign w_drop = w_ack_cap & w_full & ~w_pop;

   assign w_rd_ent = r_mem[r_rd_ptr];
   assign w_rd_ch4 = 4'(w_rd_ent[EW-1 -: CHW]);
   assign w_rd_s16 = 16'(w_rd_ent[NUM_BIT-1:0]);

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state      <= S_IDLE;
         r_adc_ena    <= 1'b0;
         r_calib_ena  <= 1'b0;
         r_ch_sel     <= '0;
         r_sample_cnt <= '0;
         r_overflow   <= 1'b0;
         r_calib_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cmd_s) begin
                  r_state      <= S_CAPTURE;
                  r_adc_ena    <= 1'b1;
                  r_ch_sel     <= '0;
                  r_sample_cnt <= '0;
                  r_overflow   <= 1'b0;
               end else if (w_cmd_c) begin
                  r_state     <= S_CALIB;
                  r_calib_ena <= 1'b1;
                  r_calib_cnt <= '0;
               end
            end
            S_CALIB: begin
               if (r_calib_cnt == 32'(NUM_CALIB - 1)) begin
                  r_calib_ena <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_calib_cnt <= r_calib_cnt + 32'd1;
               end
            end
            S_CAPTURE: begin
               if (adc_ack) begin
                  r_sample_cnt <= r_sample_cnt + 24'd1;
                  r_ch_sel     <= (r_ch_sel == CHW'(NUM_CH - 1)) ? '0 : r_ch_sel + CHW'(1);
                  if (w_drop) r_overflow <= 1'b1;
                  if (w_last) begin
                     r_state   <= S_DRAIN;
                     r_adc_ena <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (w_empty && !r_tx_wreq) r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst || w_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_ch_sel, adc_dout};
   end

   // Serializer: header byte, then one or two sample bytes shifted out of r_b1/r_b2.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_tx_wreq  <= 1'b0;
         r_tx_wdata <= 8'h00;
         r_left     <= 2'd0;
      end else if (w_pop) begin
         r_tx_wreq  <= 1'b1;
         r_tx_wdata <= {w_rd_ch4, 3'b000, r_overflow};
         r_b1       <= (NUM_BIT > 8) ? w_rd_s16[15:8] : w_rd_s16[7:0];
         r_b2       <= w_rd_s16[7:0];
         r_left     <= (NUM_BIT > 8) ? 2'd2 : 2'd1;
      end else if (r_tx_wreq && tx_rdy) begin
         if (r_left != 2'd0) begin
            r_tx_wdata <= r_b1;
            r_b1       <= r_b2;
            r_left     <= r_left - 2'd1;
         end else begin
            r_tx_wreq <= 1'b0;
         end
      end
   end

   assign adc_ena       = r_adc_ena;
   assign adc_calib_ena = r_calib_ena;
   assign adc_ch_sel    = r_ch_sel;
   assign tx_wdata      = r_tx_wdata;
   assign tx_wreq       = r_tx_wreq;
   assign state         = r_state;
   assign sample_cnt    = r_sample_cnt;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_adc_stream_ctrl.sv
// Directed bench for adc_stream_ctrl: a narrow 4-channel instance (u_a) and a
// 12-bit instance (u_b); transmitted bytes are logged and checked against hand values.
module tb_adc_stream_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [7:0]  a_cmd_data;   logic a_cmd_vld;  logic a_adc_ack;  logic [5:0] a_adc_dout;
   logic        a_adc_ena;    logic a_adc_calib_ena;  logic [1:0] a_adc_ch_sel;
   logic [7:0]  a_tx_wdata;   logic a_tx_wreq;  logic a_tx_rdy;
   logic [2:0]  a_state;      logic [23:0] a_sample_cnt;  logic a_overflow;

   logic [7:0]  b_cmd_data;   logic b_cmd_vld;  logic b_adc_ack;  logic [11:0] b_adc_dout;
   logic        b_adc_ena;    logic b_adc_calib_ena;  logic [1:0] b_adc_ch_sel;
   logic [7:0]  b_tx_wdata;   logic b_tx_wreq;  logic b_tx_rdy;
   logic [2:0]  b_state;      logic [23:0] b_sample_cnt;  logic b_overflow;

   int checks = 0;
   int failures = 0;
   logic [7:0] a_q[$];
   logic [7:0] b_q[$];

   adc_stream_ctrl #(.NUM_BIT(6), .NUM_CH(4), .NUM_SAMPLED(6), .NUM_CALIB(5), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rst(rst), .cmd_data(a_cmd_data), .cmd_vld(a_cmd_vld),
      .adc_ack(a_adc_ack), .adc_dout(a_adc_dout), .adc_ena(a_adc_ena),
      .adc_calib_ena(a_adc_calib_ena), .adc_ch_sel(a_adc_ch_sel), .tx_wdata(a_tx_wdata),
      .tx_wreq(a_tx_wreq), .tx_rdy(a_tx_rdy), .state(a_state),
      .sample_cnt(a_sample_cnt), .overflow(a_overflow));

   adc_stream_ctrl #(.NUM_BIT(12), .NUM_CH(4), .NUM_SAMPLED(3), .NUM_CALIB(2), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .cmd_data(b_cmd_data), .cmd_vld(b_cmd_vld),
      .adc_ack(b_adc_ack), .adc_dout(b_adc_dout), .adc_ena(b_adc_ena),
      .adc_calib_ena(b_adc_calib_ena), .adc_ch_sel(b_adc_ch_sel), .tx_wdata(b_tx_wdata),
      .tx_wreq(b_tx_wreq), .tx_rdy(b_tx_rdy), .state(b_state),
      .sample_cnt(b_sample_cnt), .overflow(b_overflow));

   always @(posedge clk) begin
      if (a_tx_wreq === 1'b1 && a_tx_rdy === 1'b1) a_q.push_back(a_tx_wdata);
      if (b_tx_wreq === 1'b1 && b_tx_rdy === 1'b1) b_q.push_back(b_tx_wdata);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic a_cmd(input logic [7:0] c);
      a_cmd_data = c; a_cmd_vld = 1'b1;
      @(negedge clk);
      a_cmd_vld = 1'b0;
   endtask

   task automatic b_cmd(input logic [7:0] c);
      b_cmd_data = c; b_cmd_vld = 1'b1;
      @(negedge clk);
      b_cmd_vld = 1'b0;
   endtask

   task automatic a_ack(input logic [5:0] d);
      a_adc_dout = d; a_adc_ack = 1'b1;
      @(negedge clk);
      a_adc_ack = 1'b0;
   endtask

   task automatic b_ack(input logic [11:0] d);
      b_adc_dout = d; b_adc_ack = 1'b1;
      @(negedge clk);
      b_adc_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_state, a_adc_ena, a_adc_calib_ena, a_adc_ch_sel, a_tx_wreq, a_tx_wdata, a_sample_cnt, a_overflow} !== '0) begin
         failures++;
         $display("FAIL reset_a got st=%0d ena=%b cal=%b ch=%0d wreq=%b wd=%h cnt=%0d ovf=%b exp all zero",
                  a_state, a_adc_ena, a_adc_calib_ena, a_adc_ch_sel, a_tx_wreq, a_tx_wdata, a_sample_cnt, a_overflow);
      end
      checks++;
      if ({b_state, b_adc_ena, b_adc_calib_ena, b_adc_ch_sel, b_tx_wreq, b_tx_wdata, b_sample_cnt, b_overflow} !== '0) begin
         failures++;
         $display("FAIL reset_b got st=%0d ena=%b cal=%b wreq=%b wd=%h exp all zero",
                  b_state, b_adc_ena, b_adc_calib_ena, b_tx_wreq, b_tx_wdata);
      end
   endtask

   task automatic test_calib();
      int n = 0;
      logic bad_st = 1'b0;
      logic bad_tx = 1'b0;
      a_q.delete();
      a_tx_rdy = 1'b1;
      a_cmd(8'h43);
      checks++;
      if (a_state !== 3'd1) begin
         failures++; $display("FAIL calib_enter state got=%0d exp=1", a_state);
      end
      for (int i = 0; i < 50 && a_adc_calib_ena === 1'b1; i++) begin
         n++;
         if (a_state !== 3'd1) bad_st = 1'b1;
         if (a_tx_wreq !== 1'b0) bad_tx = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (n != 5) begin
         failures++; $display("FAIL calib_len got=%0d exp=5", n);
      end
      checks++;
      if (bad_st !== 1'b0 || a_state !== 3'd0) begin
         failures++; $display("FAIL calib_state got final=%0d bad=%b exp final=0 bad=0", a_state, bad_st);
      end
      checks++;
      if (bad_tx !== 1'b0 || a_q.size() != 0) begin
         failures++; $display("FAIL calib_no_tx got wreq_seen=%b bytes=%0d exp 0 0", bad_tx, a_q.size());
      end
   endtask

   task automatic test_capture();
      a_q.delete();
      a_tx_rdy = 1'b1;
      a_cmd(8'h53);
      checks++;
      if (a_state !== 3'd2 || a_adc_ena !== 1'b1 || a_sample_cnt !== 24'd0) begin
         failures++; $display("FAIL cap_enter got st=%0d ena=%b cnt=%0d exp 2 1 0", a_state, a_adc_ena, a_sample_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (a_adc_ch_sel !== 2'(i % 4)) begin
            failures++; $display("FAIL cap_chsel[%0d] got=%0d exp=%0d", i, a_adc_ch_sel, i % 4);
         end
         a_ack(6'(i + 1));
         if (i == 5) begin
            checks++;
            if (a_state !== 3'd3 || a_adc_ena !== 1'b0 || a_sample_cnt !== 24'd6) begin
               failures++; $display("FAIL cap_last got st=%0d ena=%b cnt=%0d exp 3 0 6", a_state, a_adc_ena, a_sample_cnt);
            end
            a_ack(6'd7);
            checks++;
            if (a_sample_cnt !== 24'd6) begin
               failures++; $display("FAIL cap_late_ack cnt got=%0d exp=6", a_sample_cnt);
            end
         end
         @(negedge clk);
         if (i == 0) begin
            checks++;
            if (a_tx_wreq !== 1'b1) begin
               failures++; $display("FAIL cap_latency wreq got=%b exp=1", a_tx_wreq);
            end
         end
         cyc(3);
      end
      for (int i = 0; i < 60 && a_state !== 3'd0; i++) @(negedge clk);
      checks++;
      if (a_state !== 3'd0) begin
         failures++; $display("FAIL cap_end state got=%0d exp=0", a_state);
      end
      checks++;
      if (a_q.size() != 12) begin
         failures++; $display("FAIL cap_nbytes got=%0d exp=12", a_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         logic [7:0] e0, e1;
         e0 = 8'((k % 4) << 4);
         e1 = 8'(k + 1);
         checks++;
         if (a_q[2*k] !== e0 || a_q[2*k+1] !== e1) begin
            failures++; $display("FAIL cap_pair[%0d] got=%h,%h exp=%h,%h", k, a_q[2*k], a_q[2*k+1], e0, e1);
         end
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      a_q.delete();
      a_tx_rdy = 1'b0;
      a_cmd(8'h53);
      for (int i = 0; i < 4; i++) a_ack(6'(i + 1));
      checks++;
      if (a_overflow !== 1'b0 || a_sample_cnt !== 24'd4 || a_tx_wreq !== 1'b0) begin
         failures++; $display("FAIL full_fill got ovf=%b cnt=%0d wreq=%b exp 0 4 0", a_overflow, a_sample_cnt, a_tx_wreq);
      end
      a_tx_rdy = 1'b1;
      a_ack(6'd5);
      checks++;
      if (a_overflow !== 1'b0 || a_sample_cnt !== 24'd5) begin
         failures++; $display("FAIL full_pop_push got ovf=%b cnt=%0d exp 0 5", a_overflow, a_sample_cnt);
      end
      cyc(16);
      a_ack(6'd6);
      for (int i = 0; i < 60 && a_state !== 3'd0; i++) @(negedge clk);
      checks++;
      if (a_state !== 3'd0 || a_q.size() != 12) begin
         failures++; $display("FAIL full_end got st=%0d bytes=%0d exp 0 12", a_state, a_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         logic [7:0] e0, e1;
         e0 = 8'((k % 4) << 4);
         e1 = 8'(k + 1);
         checks++;
         if (a_q[2*k] !== e0 || a_q[2*k+1] !== e1) begin
            failures++; $display("FAIL full_pair[%0d] got=%h,%h exp=%h,%h", k, a_q[2*k], a_q[2*k+1], e0, e1);
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      a_q.delete();
      a_tx_rdy = 1'b0;
      a_cmd(8'h53);
      for (int i = 0; i < 5; i++) a_ack(6'(i + 1));
      checks++;
      if (a_overflow !== 1'b1 || a_sample_cnt !== 24'd5 || a_state !== 3'd2 || a_adc_ch_sel !== 2'd1) begin
         failures++; $display("FAIL ovf_flag got ovf=%b cnt=%0d st=%0d ch=%0d exp 1 5 2 1",
                              a_overflow, a_sample_cnt, a_state, a_adc_ch_sel);
      end
      a_tx_rdy = 1'b1;
      cyc(20);
      checks++;
      if (a_q.size() != 8) begin
         failures++; $display("FAIL ovf_nbytes got=%0d exp=8", a_q.size());
      end
      for (int k = 0; k < 4; k++) begin
         logic [7:0] e0, e1;
         e0 = 8'((k << 4) | 1);
         e1 = 8'(k + 1);
         checks++;
         if (a_q[2*k] !== e0 || a_q[2*k+1] !== e1) begin
            failures++; $display("FAIL ovf_pair[%0d] got=%h,%h exp=%h,%h", k, a_q[2*k], a_q[2*k+1], e0, e1);
         end
      end
   endtask

   task automatic test_garbage_abort();
      do_reset();
      a_tx_rdy = 1'b1;
      a_cmd(8'h53);
      a_cmd(8'h00);
      checks++;
      if (a_state !== 3'd2) begin
         failures++; $display("FAIL garbage_00 state got=%0d exp=2", a_state);
      end
      a_cmd(8'h43);
      checks++;
      if (a_state !== 3'd2 || a_adc_calib_ena !== 1'b0) begin
         failures++; $display("FAIL garbage_C got st=%0d cal=%b exp 2 0", a_state, a_adc_calib_ena);
      end
      a_ack(6'd9);
      cyc(3);
      a_ack(6'd10);
      @(negedge clk);
      a_tx_rdy = 1'b0;
      checks++;
      if (a_tx_wreq !== 1'b1 || a_tx_wdata !== 8'h10) begin
         failures++; $display("FAIL abort_pre got wreq=%b wd=%h exp 1 10", a_tx_wreq, a_tx_wdata);
      end
      cyc(2);
      checks++;
      if (a_tx_wreq !== 1'b1 || a_tx_wdata !== 8'h10) begin
         failures++; $display("FAIL abort_hold got wreq=%b wd=%h exp 1 10", a_tx_wreq, a_tx_wdata);
      end
      a_cmd(8'h52);
      checks++;
      if ({a_state, a_adc_ena, a_adc_calib_ena, a_adc_ch_sel, a_tx_wreq, a_tx_wdata, a_sample_cnt, a_overflow} !== '0) begin
         failures++;
         $display("FAIL abort_R got st=%0d ena=%b cal=%b ch=%0d wreq=%b wd=%h cnt=%0d ovf=%b exp all zero",
                  a_state, a_adc_ena, a_adc_calib_ena, a_adc_ch_sel, a_tx_wreq, a_tx_wdata, a_sample_cnt, a_overflow);
      end
   endtask

   task automatic test_wide();
      logic [7:0] exp_b [9];
      exp_b = '{8'h00, 8'h01, 8'h11, 8'h10, 8'h02, 8'h22, 8'h20, 8'h0A, 8'hBC};
      b_q.delete();
      b_tx_rdy = 1'b1;
      b_cmd(8'h53);
      b_ack(12'h111);
      cyc(4);
      b_ack(12'h222);
      cyc(4);
      b_ack(12'hABC);
      @(negedge clk);
      b_tx_rdy = 1'b0;
      checks++;
      if (b_tx_wreq !== 1'b1 || b_tx_wdata !== 8'h20) begin
         failures++; $display("FAIL wide_hdr got wreq=%b wd=%h exp 1 20", b_tx_wreq, b_tx_wdata);
      end
      cyc(3);
      checks++;
      if (b_tx_wreq !== 1'b1 || b_tx_wdata !== 8'h20) begin
         failures++; $display("FAIL wide_hold got wreq=%b wd=%h exp 1 20", b_tx_wreq, b_tx_wdata);
      end
      b_tx_rdy = 1'b1;
      for (int i = 0; i < 50 && b_state !== 3'd0; i++) @(negedge clk);
      checks++;
      if (b_state !== 3'd0 || b_q.size() != 9) begin
         failures++; $display("FAIL wide_end got st=%0d bytes=%0d exp 0 9", b_state, b_q.size());
      end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (b_q[k] !== exp_b[k]) begin
            failures++; $display("FAIL wide_byte[%0d] got=%h exp=%h", k, b_q[k], exp_b[k]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      a_cmd_data = 8'h00; a_cmd_vld = 1'b0; a_adc_ack = 1'b0; a_adc_dout = '0; a_tx_rdy = 1'b1;
      b_cmd_data = 8'h00; b_cmd_vld = 1'b0; b_adc_ack = 1'b0; b_adc_dout = '0; b_tx_rdy = 1'b1;
      @(negedge clk);
      test_reset();
      test_calib();
      test_capture();
      test_full_pop();
      test_overflow();
      test_garbage_abort();
      test_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
